// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN activation path: default widths and the
// activation stream controller state encoding.
package bnn_pkg;

    localparam int unsigned ACT_DATA_W = 16;
    localparam int unsigned ACT_ADDR_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_UNLOAD = 2'd2,
        ST_DRAIN  = 2'd3
    } act_state_e;

endpackage

// File: rtl/fifo_2deep.sv
// Two-entry valid/ready FIFO; the head entry is held stable until it is popped.
module fifo_2deep
    import bnn_pkg::*;
#(
    parameter int unsigned DATA_W = ACT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic              push;
    logic              pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    // Storage needs no reset: contents are only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/act_stream_ctrl.sv
// Moves activation words between the host streams and the activation RAM ports.
// Unload reads are credit-limited so the 2-entry FIFO absorbs any backpressure.
module act_stream_ctrl
    import bnn_pkg::*;
#(
    parameter int unsigned DATA_W = ACT_DATA_W,
    parameter int unsigned ADDR_W = ACT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_load,
    input  logic              start_unload,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_words,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] act_addr_wr,
    output logic [DATA_W-1:0] act_data_wr,
    output logic [DATA_W-1:0] act_enb_wr,
    output logic [ADDR_W-1:0] act_addr_rd,
    input  logic [DATA_W-1:0] act_data_rd,
    output logic              idle,
    output logic              done
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    act_state_e        state;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [CNT_W-1:0]  wr_left;
    logic [CNT_W-1:0]  rd_left;
    logic              rd_pend;
    logic              rd_issue;
    logic              in_beat;
    logic              fifo_in_ready;
    logic              fifo_pop;
    logic [1:0]        fifo_count;
    logic [1:0]        occ_next;

    assign idle        = (state == ST_IDLE);
    assign in_ready    = (state == ST_LOAD);
    assign in_beat     = in_valid && in_ready;
    assign act_addr_wr = wr_addr;
    assign act_data_wr = in_data;
    assign act_enb_wr  = {DATA_W{in_beat}};
    assign fifo_pop    = out_valid && out_ready;
    // Occupancy the FIFO will need to absorb if no new read is issued this cycle.
    assign occ_next    = fifo_count + 2'(rd_pend) - 2'(fifo_pop);

    // The first unload read is issued in the accepting cycle to keep the 2-cycle latency.
    always_comb begin
        rd_issue    = 1'b0;
        act_addr_rd = rd_addr;
        case (state)
            ST_IDLE: begin
                if (start_unload && !start_load && (num_words != '0)) begin
                    rd_issue    = 1'b1;
                    act_addr_rd = base_addr;
                end
            end
            ST_UNLOAD: rd_issue = (occ_next < 2'd2);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            wr_addr <= '0;
            rd_addr <= '0;
            wr_left <= '0;
            rd_left <= '0;
            rd_pend <= 1'b0;
            done    <= 1'b0;
        end else begin
            done    <= 1'b0;
            rd_pend <= rd_issue;
            case (state)
                ST_IDLE: begin
                    if (start_load || start_unload) begin
                        if (num_words == '0) begin
                            done <= 1'b1;
                        end else if (start_load) begin
                            state   <= ST_LOAD;
                            wr_addr <= base_addr;
                            wr_left <= num_words;
                        end else begin
                            state   <= (num_words == CNT_W'(1)) ? ST_DRAIN : ST_UNLOAD;
                            rd_addr <= base_addr + ADDR_W'(1);
                            rd_left <= num_words - CNT_W'(1);
                        end
                    end
                end
                ST_LOAD: begin
                    if (in_beat) begin
                        wr_addr <= wr_addr + ADDR_W'(1);
                        wr_left <= wr_left - CNT_W'(1);
                        if (wr_left == CNT_W'(1)) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_UNLOAD: begin
                    if (rd_issue) begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                        rd_left <= rd_left - CNT_W'(1);
                        if (rd_left == CNT_W'(1)) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!out_valid && !rd_pend) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    fifo_2deep #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rd_pend && fifo_in_ready),
        .in_ready  (fifo_in_ready),
        .in_data   (act_data_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_act_stream_ctrl.sv
// Scoreboard bench for act_stream_ctrl with a behavioural activation RAM.
module tb_act_stream_ctrl;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 7;
    localparam int unsigned DEPTH = 128;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_load, start_unload;
    logic [AW-1:0] base_addr;
    logic [AW:0]   num_words;
    logic [DW-1:0] in_data;
    logic          in_valid, in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid, out_ready;
    logic [AW-1:0] act_addr_wr, act_addr_rd;
    logic [DW-1:0] act_data_wr, act_enb_wr, act_data_rd;
    logic          idle, done;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int pops = 0;

    logic [DW-1:0] ram     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    wr_t           wq [$];
    logic [DW-1:0] oq [$];
    logic [DW-1:0] fixed_data [$];
    logic          stall_q = 1'b0;
    logic [DW-1:0] stall_data;

    act_stream_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_load   (start_load),
        .start_unload (start_unload),
        .base_addr    (base_addr),
        .num_words    (num_words),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .act_addr_wr  (act_addr_wr),
        .act_data_wr  (act_data_wr),
        .act_enb_wr   (act_enb_wr),
        .act_addr_rd  (act_addr_rd),
        .act_data_rd  (act_data_rd),
        .idle         (idle),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Activation RAM: masked write, read data one cycle after the address.
    always @(posedge clk) begin
        if (act_enb_wr != '0)
            ram[act_addr_wr] <= (ram[act_addr_wr] & ~act_enb_wr) | (act_data_wr & act_enb_wr);
        act_data_rd <= ram[act_addr_rd];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: RAM writes, unload beats, stall stability, done pulses.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (act_enb_wr != '0) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", 32'(act_addr_wr), 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    chk("wr_addr", 32'(act_addr_wr), 32'(e.addr));
                    chk("wr_data", 32'(act_data_wr), 32'(e.data));
                    chk("wr_enb", 32'(act_enb_wr), 32'hFFFF);
                end
            end
            if (stall_q) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", 32'(out_data), 32'(stall_data));
            end
            if (out_valid && out_ready) begin
                if (oq.size() == 0) begin
                    chk("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    logic [DW-1:0] e;
                    e = oq.pop_front();
                    chk("out_data", 32'(out_data), 32'(e));
                end
                pops++;
            end
            stall_q    = out_valid && !out_ready;
            stall_data = out_data;
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // vmode 0: in_valid held high, 1: random in_valid.
    task automatic load_xfer(input int base, input int n, input int vmode);
        int sent = 0;
        int guard = 0;
        int d0 = done_cnt;
        start_load = 1'b1;
        base_addr  = AW'(base);
        num_words  = (AW+1)'(n);
        tick();
        start_load = 1'b0;
        while (sent < n && guard < 4000) begin
            guard++;
            in_valid = (vmode == 0) || ($urandom_range(0, 1) == 1);
            in_data  = (fixed_data.size() != 0) ? fixed_data[0] : DW'($urandom);
            if (in_valid && in_ready) begin
                wq.push_back('{addr: AW'(base + sent), data: in_data});
                ref_mem[(base + sent) % DEPTH] = in_data;
                if (fixed_data.size() != 0) void'(fixed_data.pop_front());
                sent++;
            end
            tick();
        end
        in_valid = 1'b0;
        if (sent < n) chk("load_timeout", 32'(sent), 32'(n));
        chk("load_done_pulse", 32'(done), 32'd1);
        chk("load_idle_after", 32'(idle), 32'd1);
        tick();
        chk("load_done_count", 32'(done_cnt - d0), 32'd1);
        chk("load_wq_empty", 32'(wq.size()), 32'd0);
    endtask

    // rmode 0: out_ready high (latency/streaming checked), 1: toggling, 2: random.
    task automatic unload_xfer(input int base, input int n, input int rmode);
        int guard = 0;
        int cyc = 1;
        int d0 = done_cnt;
        for (int i = 0; i < n; i++) oq.push_back(ref_mem[(base + i) % DEPTH]);
        start_unload = 1'b1;
        base_addr    = AW'(base);
        num_words    = (AW+1)'(n);
        out_ready    = (rmode != 2) ? 1'b1 : 1'($urandom_range(0, 1));
        tick();
        start_unload = 1'b0;
        while ((oq.size() != 0 || done_cnt == d0) && guard < 4000) begin
            guard++;
            if (rmode == 0 && cyc == 1) chk("unload_lat_c1", 32'(out_valid), 32'd0);
            if (rmode == 0 && cyc >= 2 && cyc < 2 + n) chk("unload_stream", 32'(out_valid), 32'd1);
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = 1'((cyc + 1) % 2);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            tick();
            cyc++;
        end
        if (guard >= 4000) chk("unload_timeout", 32'(oq.size()), 32'd0);
        out_ready = 1'b0;
        tick();
        chk("unload_done_count", 32'(done_cnt - d0), 32'd1);
        chk("unload_idle_after", 32'(idle), 32'd1);
        chk("unload_out_valid_after", 32'(out_valid), 32'd0);
    endtask

    task automatic zero_start(input logic both);
        int d0 = done_cnt;
        start_load   = both;
        start_unload = 1'b1;
        base_addr    = AW'($urandom);
        num_words    = '0;
        tick();
        start_load   = 1'b0;
        start_unload = 1'b0;
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_idle", 32'(idle), 32'd1);
        chk("zero_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("zero_done_once", 32'(done), 32'd0);
        chk("zero_out_valid", 32'(out_valid), 32'd0);
        tick();
        chk("zero_idle_hold", 32'(idle), 32'd1);
        chk("zero_done_count", 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            ram[i]     = '0;
            ref_mem[i] = '0;
        end
        rst_n = 1'b0; start_load = 1'b0; start_unload = 1'b0;
        base_addr = '0; num_words = '0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_enb", 32'(act_enb_wr), 32'd0);
        chk("rst_addr_wr", 32'(act_addr_wr), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        fixed_data.push_back(16'hAAAA);
        fixed_data.push_back(16'h5555);
        fixed_data.push_back(16'h1234);
        load_xfer(5, 3, 0);
        load_xfer(126, 4, 0);
        load_xfer(0, 128, 1);
        unload_xfer(0, 8, 1);
        unload_xfer(77, 128, 0);
        zero_start(1'b1);
        zero_start(1'b0);

        // Reset during an unload stream after three words have left.
        begin
            int guard = 0;
            int d0;
            int p0 = pops;
            for (int i = 0; i < 20; i++) oq.push_back(ref_mem[(40 + i) % DEPTH]);
            start_unload = 1'b1; base_addr = AW'(40); num_words = (AW+1)'(20); out_ready = 1'b1;
            tick();
            start_unload = 1'b0;
            while (pops - p0 < 3 && guard < 100) begin
                guard++;
                tick();
            end
            chk("rst_mid_progress", 32'(pops - p0 >= 3), 32'd1);
            d0 = done_cnt;
            rst_n = 1'b0;
            #1;
            chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
            chk("rst_mid_idle", 32'(idle), 32'd1);
            chk("rst_mid_done", 32'(done), 32'd0);
            oq.delete();
            wq.delete();
            tick();
            tick();
            rst_n = 1'b1;
            out_ready = 1'b0;
            repeat (4) tick();
            chk("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
        end
        unload_xfer(3, 5, 0);

        for (int it = 0; it < 16; it++) begin
            int base = $urandom_range(0, DEPTH - 1);
            int n = $urandom_range(1, 24);
            case ($urandom_range(0, 4))
                0: zero_start(1'($urandom_range(0, 1)));
                1, 2: load_xfer(base, n, 1);
                default: unload_xfer(base, n, 2);
            endcase
        end
        unload_xfer(120, 16, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/act_stream_ctrl.md
ACT_STREAM_CTRL -- requirements
Module: act_stream_ctrl

Interface
REQ-001 Parameter DATA_W, 16, activation word width; equals activation RAM width.
REQ-002 Parameter ADDR_W, 7, activation RAM address width (depth 2**ADDR_W = 128).
REQ-003 Clocking SHALL be one clock, clk; reset SHALL be asynchronous active-low, rst_n.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start_load  in  1  one-cycle pulse; begin host-to-RAM transfer.
REQ-007 start_unload  in  1  one-cycle pulse; begin RAM-to-host transfer.
REQ-008 base_addr  in  ADDR_W  first RAM word address; sampled on accepted start.
REQ-009 num_words  in  ADDR_W+1  word count 0..128; sampled on accepted start.
REQ-010 in_data / in_valid / in_ready  in/in/out  DATA_W/1/1  host load stream.
REQ-011 out_data / out_valid / out_ready  out/out/in  DATA_W/1/1  host unload stream.
REQ-012 act_addr_wr / act_data_wr / act_enb_wr  out  ADDR_W/DATA_W/DATA_W  RAM write port; enb is per-bit write mask.
REQ-013 act_addr_rd  out  ADDR_W  RAM read address; act_data_rd  in  DATA_W  read data, valid exactly 1 cycle after address.
REQ-014 idle  out  1  high only in IDLE; drives datapath idle (host owns activation RAM).
REQ-015 done  out  1  one-cycle pulse when a transfer completes.

Function
REQ-016 States SHALL be IDLE, LOAD, UNLOAD, DRAIN; no other states.
REQ-017 IDLE: start_load accepted -> LOAD; else start_unload accepted -> UNLOAD; both same cycle -> LOAD wins, unload dropped.
REQ-018 Starts SHALL be ignored outside IDLE.
REQ-019 num_words==0 on accepted start: stay IDLE, pulse done next cycle, no RAM access.
REQ-020 LOAD: in_ready=1; each in_valid&&in_ready beat writes in_data to current address same cycle with act_enb_wr=all ones; act_enb_wr=0 on every other cycle and state.
REQ-021 Address SHALL increment by 1 per word, wrapping mod 128 (127 -> 0).
REQ-022 LOAD exits to IDLE the cycle after the final beat; done pulses in that IDLE cycle.
REQ-023 UNLOAD: issue one read per cycle while credit allows; results pushed into a 2-entry FIFO feeding out_*.
REQ-024 Read issue SHALL require FIFO occupancy + reads in flight < 2, so no word is lost under out_ready backpressure.
REQ-025 After the last read is issued -> DRAIN; DRAIN -> IDLE when FIFO empty and no read in flight; done pulses that IDLE cycle.
REQ-026 out_valid = FIFO non-empty; out_data = FIFO head; out_data/out_valid SHALL hold stable while out_valid && !out_ready.
REQ-027 Unload words SHALL emerge in address order with no gap when out_ready held high (1 word/cycle after 2-cycle initial latency).
REQ-028 in_ready=0 and out_valid=0 in IDLE.
REQ-029 Word counter SHALL be ADDR_W+1 bits so 128 is representable; a 128-word transfer touches every address once.

Reset
REQ-030 rst_n low SHALL asynchronously force: state IDLE, idle=1, in_ready=0, out_valid=0, done=0, act_enb_wr=0, all addresses/counters 0, FIFO empty.
REQ-031 Reset mid-transfer SHALL abort it with no done pulse; partially written RAM contents remain.
REQ-032 act_data_wr and out_data values are don't-care when their qualifiers are low.

Structure
REQ-033 State enum and ADDR_W/DATA_W defaults SHALL live in shared package bnn_pkg.
REQ-034 The 2-entry output FIFO SHALL be a sub-module, fifo_2deep, with valid/ready on both sides.
REQ-035 Target RTL size 150-300 lines; no RAM instantiated inside this block.

Verification
REQ-036 Load base=5, n=3, data 0xAAAA,0x5555,0x1234, in_valid continuous -> writes at 5,6,7, enb=0xFFFF, done 1 cycle after third beat.
REQ-037 Load base=126, n=4 -> writes at 126,127,0,1 (wrap).
REQ-038 Unload base=0, n=8, out_ready toggling 1010... -> 8 words in order, none dropped/duplicated, data stable during stalls.
REQ-039 Unload n=128, out_ready=1 -> first out_valid 2 cycles after start, 128 consecutive beats, then done.
REQ-040 start_load and start_unload same cycle, n=0 -> no RAM access, done pulse next cycle, idle stays 1.
REQ-041 rst_n asserted mid-unload after 3 words -> out_valid=0 and idle=1 immediately, no done; next start works normally.
